// File: rtl/ascii_rf_loader_pkg.sv
// ascii_rf_loader_pkg
//   Shared constants and state encoding for the ASCII register-file loader.
//   The downstream digit scanner uses the same DEPTH/AW, so both sides
//   import this package.
package ascii_rf_loader_pkg;

    localparam int DEPTH = 16;             // register-file entries to fill
    localparam int AW    = 4;              // log2(DEPTH)
    localparam int DW    = 8;              // data width

    localparam logic [DW-1:0] TERM_CHAR = 8'h0D;   // CR, ends input early, never stored
    localparam logic [DW-1:0] PAD_CHAR  = 8'h20;   // space, fills entries after TERM

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_PAD   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_GO    = 3'd4
    } state_e;

endpackage

// File: rtl/ascii_rf_loader_if.sv
// ascii_rf_loader_if
//   Groups the loader's control, byte-stream and register-file write signals.
//   slave  : the loader itself
//   master : the byte source / controller (and the testbench)
//   Signals:
//     start       begin a load (sampled in IDLE only)
//     in_data     ASCII byte, in_valid/in_ready handshake
//     W_Addr/W_en/W_Data  registered register-file write port
//     go          one-cycle pulse once all entries are written
//     busy        loader not idle
//     loaded_cnt  bytes stored before the terminator (0..DEPTH)
interface ascii_rf_loader_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] W_Addr;
    logic          W_en;
    logic [DW-1:0] W_Data;
    logic          go;
    logic          busy;
    logic [AW:0]   loaded_cnt;

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, W_Addr, W_en, W_Data, go, busy, loaded_cnt
    );

    modport master (
        output start, in_data, in_valid,
        input  in_ready, W_Addr, W_en, W_Data, go, busy, loaded_cnt
    );

endinterface

// File: rtl/ascii_rf_loader.sv
// ascii_rf_loader
//   Loads an ASCII byte stream into register-file entries 0..DEPTH-1 in order.
//   A TERM_CHAR byte ends input early; remaining entries get PAD_CHAR. After
//   the last write has been on the bus, go pulses for one cycle.
//   Ports:
//     Clk  system clock
//     Rst  synchronous active-high reset
//     bus  ascii_rf_loader_if.slave (handshake, write port, status)
module ascii_rf_loader
    import ascii_rf_loader_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    ascii_rf_loader_if.slave  bus
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [AW:0]   cnt_q,   cnt_d;
    logic          wen_q,   wen_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          go_q,    go_d;

    logic accept;

    // Only RECV takes bytes; a byte presented with start in IDLE is left alone.
    assign accept = bus.in_valid && (state_q == ST_RECV);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        go_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RECV;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_RECV: begin
                if (accept) begin
                    if (bus.in_data == TERM_CHAR) begin
                        // Terminator is consumed but not stored; padding starts at addr.
                        state_d = ST_PAD;
                    end else begin
                        wen_d   = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = bus.in_data;
                        cnt_d   = cnt_q + (AW+1)'(1);
                        // addr saturates at the last entry instead of wrapping
                        if (addr_q == LAST_ADDR) state_d = ST_FLUSH;
                        else                     addr_d  = addr_q + AW'(1);
                    end
                end
            end
            ST_PAD: begin
                wen_d   = 1'b1;
                waddr_d = addr_q;
                wdata_d = PAD_CHAR;
                if (addr_q == LAST_ADDR) state_d = ST_FLUSH;
                else                     addr_d  = addr_q + AW'(1);
            end
            ST_FLUSH: begin
                // final registered write is visible on the bus this cycle
                state_d = ST_GO;
                go_d    = 1'b1;
            end
            ST_GO: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            go_q    <= go_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_RECV);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.W_en       = wen_q;
    assign bus.W_Addr     = waddr_q;
    assign bus.W_Data     = wdata_q;
    assign bus.go         = go_q;
    assign bus.loaded_cnt = cnt_q;

endmodule

// File: tb/tb_ascii_rf_loader.sv
// tb_ascii_rf_loader
//   Table-driven checks of whole loads plus hand-written sequences for
//   mid-load reset and start/valid overlap.
module tb_ascii_rf_loader;

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    ascii_rf_loader_if #(.AW(4), .DW(8)) bus ();

    ascii_rf_loader dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    typedef struct {
        string             s;          // bytes to send, in order
        bit                gap;        // idle cycle between bytes
        bit                hold_extra; // keep offering 'G' after the last byte
        logic [15:0][7:0]  exp_mem;    // entry i in byte i
        int                exp_cnt;
        int                exp_acc;
    } vec_t;

    vec_t vecs[5];

    int n_tests = 0;
    int n_fail  = 0;

    // observed-bus model
    logic [15:0][7:0] m;
    int hits[16];
    int wcnt, acc_cnt, go_cnt, go_bad;
    logic       prev_wen;
    logic [3:0] prev_addr;

    always @(negedge Clk) begin
        if (bus.in_valid && bus.in_ready) acc_cnt++;
        if (bus.W_en) begin
            m[bus.W_Addr] = bus.W_Data;
            hits[bus.W_Addr]++;
            wcnt++;
        end
        if (bus.go) begin
            go_cnt++;
            if (!(prev_wen && prev_addr == 4'd15 && !bus.W_en)) go_bad++;
        end
        prev_wen  = bus.W_en;
        prev_addr = bus.W_Addr;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        m = '0;
        for (int i = 0; i < 16; i++) hits[i] = 0;
        wcnt = 0; acc_cnt = 0; go_cnt = 0; go_bad = 0;
    endtask

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        #1;
        while (!bus.in_ready && t < 40) begin
            @(posedge Clk); #1; t++;
        end
        if (t >= 40) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: byte %0h not accepted in 40 cycles", b);
        end
        @(posedge Clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_go();
        int t = 0;
        while (go_cnt == 0 && t < 80) begin
            @(posedge Clk); #1; t++;
        end
        if (t >= 80) begin
            n_tests++; n_fail++;
            $display("FAIL go_timeout: no go within 80 cycles");
        end
        repeat (2) @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge Clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic check_load(input string tag, input logic [15:0][7:0] exp_mem,
                              input int exp_cnt, input int exp_acc);
        int maxh = 0;
        for (int i = 0; i < 16; i++) if (hits[i] > maxh) maxh = hits[i];
        chk({tag, "_mem"},  m, exp_mem);
        chk({tag, "_wcnt"}, 128'(wcnt), 128'd16);
        chk({tag, "_dup"},  128'(maxh), 128'd1);
        chk({tag, "_acc"},  128'(acc_cnt), 128'(exp_acc));
        chk({tag, "_cnt"},  128'(bus.loaded_cnt), 128'(exp_cnt));
        chk({tag, "_go"},   128'(go_cnt), 128'd1);
        chk({tag, "_gopos"}, 128'(go_bad), 128'd0);
        chk({tag, "_busy"}, 128'({bus.busy, bus.in_ready, bus.W_en}), 128'd0);
    endtask

    task automatic run_vec(input int v);
        clear_model();
        pulse_start();
        for (int i = 0; i < vecs[v].s.len(); i++) begin
            if (vecs[v].gap && i > 0) begin
                @(posedge Clk); #1;
            end
            send_byte(vecs[v].s[i]);
        end
        if (vecs[v].hold_extra) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h47;
            #1;
            chk($sformatf("v%0d_rdy17", v), 128'(bus.in_ready), 128'd0);
        end
        wait_go();
        bus.in_valid = 1'b0;
        check_load($sformatf("v%0d", v), vecs[v].exp_mem, vecs[v].exp_cnt, vecs[v].exp_acc);
    endtask

    initial begin
        vecs[0] = '{s: "12A\015", gap: 1'b0, hold_extra: 1'b0,
                    exp_mem: {{13{8'h20}}, 8'h41, 8'h32, 8'h31}, exp_cnt: 3, exp_acc: 4};
        vecs[1] = '{s: "0123456789ABCDEF", gap: 1'b0, hold_extra: 1'b1,
                    exp_mem: "FEDCBA9876543210", exp_cnt: 16, exp_acc: 16};
        vecs[2] = '{s: "\015", gap: 1'b0, hold_extra: 1'b0,
                    exp_mem: {16{8'h20}}, exp_cnt: 0, exp_acc: 1};
        vecs[3] = '{s: "0123456789ABCDE\015", gap: 1'b0, hold_extra: 1'b0,
                    exp_mem: {8'h20, "EDCBA9876543210"}, exp_cnt: 15, exp_acc: 16};
        vecs[4] = '{s: "5\015", gap: 1'b1, hold_extra: 1'b0,
                    exp_mem: {{15{8'h20}}, 8'h35}, exp_cnt: 1, exp_acc: 2};

        clear_model();
        Rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_outs", 128'({bus.W_en, bus.W_Addr, bus.W_Data, bus.go,
                                bus.loaded_cnt, bus.busy, bus.in_ready}), 128'd0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        for (int v = 0; v < 5; v++) run_vec(v);

        // reset after 5 accepted bytes
        clear_model();
        pulse_start();
        send_byte(8'h48); send_byte(8'h45); send_byte(8'h4C);
        send_byte(8'h4C); send_byte(8'h4F);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        chk("midrst_outs", 128'({bus.busy, bus.W_en, bus.go}), 128'd0);
        repeat (20) @(posedge Clk);
        #1;
        chk("midrst_nogo", 128'(go_cnt), 128'd0);
        chk("midrst_wcnt", 128'(wcnt), 128'd5);
        chk("midrst_mem",  128'(m[4:0]), 128'h4F4C4C4548);
        run_vec(0);

        // start with in_valid in IDLE; start pulsed during RECV
        clear_model();
        bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h35;
        #1;
        chk("ovl_rdy_idle", 128'(bus.in_ready), 128'd0);
        @(posedge Clk); #1;
        bus.start = 1'b0;
        chk("ovl_noacc", 128'(acc_cnt), 128'd0);
        send_byte(8'h35);
        pulse_start();
        send_byte(8'h36);
        send_byte(8'h0D);
        wait_go();
        check_load("ovl", {{14{8'h20}}, 8'h36, 8'h35}, 2, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
